// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a small byte FIFO and CTS flow control.
// Feeds the BLE module's RX pin from the pixel clock domain.
`timescale 1ns/1ps
module uart_tx_buffered #(
    parameter int unsigned BAUD_COUNT = 645,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          cts_n_in,
    output logic                          tx_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BAUD_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Reset asserts asynchronously, releases on a clock edge
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_pipe <= 2'b00;
        else           rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    // CTS synchronizer; resets to "blocked"
    logic cts_meta;
    logic cts_sync;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n_in;
            cts_sync <= cts_meta;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;
    logic          can_send;
    logic          ready_d;

    assign push     = valid_in && ready_out;
    assign can_send = (fifo_count_out != '0) && !cts_sync;

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_comb begin
        count_d = fifo_count_out;
        if (push && !pop)      count_d = CW'(fifo_count_out + 1'b1);
        else if (!push && pop) count_d = CW'(fifo_count_out - 1'b1);
        ready_d = (count_d < CW'(FIFO_DEPTH));
    end

    state_t        state_q;
    state_t        state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          baud_end;
    logic          tx_d;
    logic          busy_d;

    assign baud_end = (baud_q == BW'(BAUD_COUNT - 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            baud_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count_out <= '0;
            ready_out      <= 1'b1;
            tx_out         <= 1'b1;
            busy_out       <= 1'b0;
        end else begin
            state_q        <= state_d;
            baud_q         <= baud_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            fifo_count_out <= count_d;
            ready_out      <= ready_d;
            tx_out         <= tx_d;
            busy_out       <= busy_d;
            if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
        end
    end

    // Next state; tx/busy are derived from the next state so tx_out is a clean flop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (can_send) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = BW'(baud_q + 1'b1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = 3'(bit_q + 1'b1);
                end else begin
                    baud_d = BW'(baud_q + 1'b1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (can_send) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = BW'(baud_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: bit-level frame table plus a
// serial-decoder scoreboard for ordering, flow control and reset cases.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int BAUD  = 8;
    localparam int DEPTH = 4;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       cts_n_in;
    logic       tx_out;
    logic       busy_out;
    logic [2:0] fifo_count_out;

    uart_tx_buffered #(.BAUD_COUNT(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .cts_n_in       (cts_n_in),
        .tx_out         (tx_out),
        .busy_out       (busy_out),
        .fifo_count_out (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         rst_gen = 0;
    int         n_rx = 0;
    logic [7:0] exp_q [$];

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted byte is expected on the line, in order
    always @(posedge clk_in) begin
        if (rst_n_in && valid_in && ready_out) exp_q.push_back(data_in);
    end

    always @(negedge rst_n_in) begin
        rst_gen++;
        exp_q.delete();
    end

    // Serial decoder: samples mid-bit on the falling clock edge
    logic       rx_prev = 1'b1;
    logic       rx_start;
    logic       rx_stop;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    int         rx_gen;

    initial begin
        forever begin
            @(negedge clk_in);
            if (rx_prev && tx_out === 1'b0) begin
                rx_gen = rst_gen;
                repeat (BAUD / 2) @(negedge clk_in);
                rx_start = tx_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk_in);
                    rx_byte[i] = tx_out;
                end
                repeat (BAUD) @(negedge clk_in);
                rx_stop = tx_out;
                if (rx_gen == rst_gen) begin
                    check("rx_start_bit", 32'(rx_start), 32'd0);
                    check("rx_stop_bit", 32'(rx_stop), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_unexpected_frame: got 0x%02h expected no frame", rx_byte);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        check("rx_byte", 32'(rx_byte), 32'(rx_exp));
                    end
                    n_rx++;
                end
                rx_prev = 1'b1;
            end else begin
                rx_prev = (tx_out !== 1'b0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        @(negedge clk_in);
        data_in  = d;
        valid_in = 1'b1;
        while (!ready_out && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("push_ready", 32'(ready_out), 32'd1);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_tx_fall(input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
        end while (tx_out !== 1'b0 && n < max_cyc);
        check("tx_fall_seen", 32'(tx_out), 32'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_tx"},    32'(tx_out),         32'd1);
        check({name, "_busy"},  32'(busy_out),       32'd0);
        check({name, "_ready"}, 32'(ready_out),      32'd1);
        check({name, "_count"}, 32'(fifo_count_out), 32'd0);
    endtask

    initial begin
        int         n;
        logic [9:0] frame;
        logic [7:0] r;

        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[3] = '{data: 8'h5A, frame: 10'b1_0101_1010_0};

        rst_n_in = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        cts_n_in = 1'b1;

        // 1: reset and quiet idle
        #2 rst_n_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check_idle("in_reset");
        rst_n_in = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_in);
            #1;
            check_idle("idle_after_reset");
        end

        // 2: table of single frames, bit-exact timing from the pop edge
        @(negedge clk_in);
        cts_n_in = 1'b0;
        repeat (5) @(negedge clk_in);
        for (int v = 0; v < 4; v++) begin
            frame = vecs[v].frame;
            push_byte(vecs[v].data);
            check("count_after_push", 32'(fifo_count_out), 32'd1);
            for (int k = 0; k < 10 * BAUD; k++) begin
                @(posedge clk_in);
                #1;
                check("frame_tx", 32'(tx_out), 32'(frame[k / BAUD]));
                check("frame_busy", 32'(busy_out), 32'd1);
            end
            @(posedge clk_in);
            #1;
            check("frame_end_busy", 32'(busy_out), 32'd0);
            check("frame_end_tx", 32'(tx_out), 32'd1);
            check("frame_end_count", 32'(fifo_count_out), 32'd0);
        end

        // 3: fill while blocked, then back-to-back drain
        @(negedge clk_in);
        cts_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        check("full_ready", 32'(ready_out), 32'd0);
        check("full_count", 32'(fifo_count_out), 32'd4);
        @(negedge clk_in);
        data_in  = 8'hFF;
        valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_in);
            #1;
            check("full_hold_count", 32'(fifo_count_out), 32'd4);
            check("full_hold_ready", 32'(ready_out), 32'd0);
            check("blocked_tx", 32'(tx_out), 32'd1);
        end
        valid_in = 1'b0;
        @(negedge clk_in);
        cts_n_in = 1'b0;
        wait_tx_fall(10, n);
        check("burst_count_0", 32'(fifo_count_out), 32'd3);
        for (int k = 1; k < 40 * BAUD; k++) begin
            @(posedge clk_in);
            #1;
            check("burst_busy", 32'(busy_out), 32'd1);
            if (k % (10 * BAUD) == 0) begin
                check("burst_start_no_gap", 32'(tx_out), 32'd0);
                check("burst_count", 32'(fifo_count_out), 32'(3 - k / (10 * BAUD)));
            end
        end
        @(posedge clk_in);
        #1;
        check("burst_end_busy", 32'(busy_out), 32'd0);
        check("burst_end_tx", 32'(tx_out), 32'd1);

        // 4: CTS raised mid-frame, resumed later
        repeat (5) @(negedge clk_in);
        push_byte(8'h3C);
        push_byte(8'h7E);
        check("cts_frame_started", 32'(tx_out), 32'd0);
        check("cts_count", 32'(fifo_count_out), 32'd1);
        repeat (34) @(posedge clk_in);
        @(negedge clk_in);
        cts_n_in = 1'b1;
        repeat (55) @(posedge clk_in);
        #1;
        check("cts_hold_busy", 32'(busy_out), 32'd0);
        check("cts_hold_tx", 32'(tx_out), 32'd1);
        check("cts_hold_count", 32'(fifo_count_out), 32'd1);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_in);
            #1;
            check("cts_hold_line", 32'(tx_out), 32'd1);
        end
        @(negedge clk_in);
        cts_n_in = 1'b0;
        wait_tx_fall(10, n);
        check("cts_resume_latency_le3", 32'(n <= 3), 32'd1);
        repeat (10 * BAUD + 10) @(posedge clk_in);

        // 5: reset mid-frame with bytes queued
        push_byte(8'h55);
        push_byte(8'hAA);
        push_byte(8'hBB);
        check("rst_pre_count", 32'(fifo_count_out), 32'd2);
        repeat (30) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_pre_busy", 32'(busy_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check_idle("abort_reset");
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_in);
            #1;
            check("post_abort_tx", 32'(tx_out), 32'd1);
            check("post_abort_busy", 32'(busy_out), 32'd0);
        end

        // 6: steady count of 3 with push coinciding with each pop
        @(negedge clk_in);
        cts_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(255));
            push_byte(r);
        end
        check("steady_fill", 32'(fifo_count_out), 32'd3);
        @(negedge clk_in);
        cts_n_in = 1'b0;
        wait_tx_fall(10, n);
        check("steady_first_pop", 32'(fifo_count_out), 32'd2);
        r = 8'($urandom_range(255));
        push_byte(r);
        check("steady_refill", 32'(fifo_count_out), 32'd3);
        repeat (10 * BAUD - 2) @(posedge clk_in);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            data_in  = 8'($urandom_range(255));
            valid_in = 1'b1;
            @(posedge clk_in);
            #1;
            valid_in = 1'b0;
            check("steady_count", 32'(fifo_count_out), 32'd3);
            check("steady_new_start", 32'(tx_out), 32'd0);
            repeat (10 * BAUD - 1) @(posedge clk_in);
        end
        repeat (4 * 10 * BAUD + 20) @(posedge clk_in);
        #1;
        check_idle("drained");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- 8N1 UART transmitter: the outbound counterpart to the existing `uart_rx`, driving the BLE module's RX pin (`ble_uart_rx`) from the pixel clock domain.
- Accepts bytes through a valid/ready handshake into a small FIFO, then serializes them with hardware flow control from the module's RTS line.
- Gameplay logic uses it to send score and state telemetry back to the phone.

Parameters:
- BAUD_COUNT, 645: `clk_in` cycles per bit (74.25 MHz / 115200). Must be ≥ 2.
- FIFO_DEPTH, 4: byte FIFO entries. Power of two, ≥ 2.

Ports:
- clk_in  input  1  pixel clock; all logic on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- data_in  input  8  byte to send.
- valid_in  input  1  `data_in` valid.
- ready_out  output  1  FIFO can accept; a transfer occurs on a rising edge where valid_in && ready_out.
- cts_n_in  input  1  clear-to-send from the module (its RTS), active-low, asynchronous to `clk_in`.
- tx_out  output  1  serial line; idles high.
- busy_out  output  1  high while a frame is on the line.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight.

Behaviour:
- Reset (async assert, sync release):
  - tx_out=1, busy_out=0, ready_out=1, fifo_count_out=0.
  - FSM=IDLE; baud counter, bit index and FIFO pointers cleared; queued bytes discarded.
  - Reset mid-frame aborts the frame immediately and the line returns high.
- CTS synchronizer: `cts_n_in` passes through a 2-flop synchronizer (`cts_sync`). Its reset value is 1, i.e. blocked.
- FIFO:
  - ready_out is registered and equals (count < FIFO_DEPTH) as of the previous edge.
  - A push when full is impossible because ready_out is low.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop happens only on the IDLE→START or STOP→START transition.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_out=1, busy_out=0. If count>0 && cts_sync==0, pop the head into the shift register and go to START.
  - START: tx_out=0 for exactly BAUD_COUNT cycles, then go to DATA with bit index 0.
  - DATA: tx_out=shift[0] for BAUD_COUNT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx_out=1 for BAUD_COUNT cycles. At the end: if count>0 && cts_sync==0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_COUNT-1 and reloads at each state or bit boundary.
  - A frame lasts exactly 10*BAUD_COUNT cycles, measured from tx_out falling to the end of the stop bit.
- busy_out is 1 in START, DATA and STOP.
- tx_out is registered (glitch-free).
- Latency, with cts_sync already 0 and FIFO empty in IDLE:
  - Handshake at edge E0.
  - FSM pops at E1.
  - tx_out falls after E1 and is observed low at the start of the cycle following E1.
- CTS deasserted mid-frame: the current frame completes. No new frame starts until cts_sync returns to 0.
- CTS assertion latency: a new frame starts no more than 3 cycles after cts_n_in falls, provided the FIFO is non-empty and the FSM is in IDLE.
- valid_in while ready_out=0: ignored. Upstream must hold data_in/valid_in until the transfer occurs.

Test Plan (BAUD_COUNT=8, FIFO_DEPTH=4):
1. Reset hold, then release with no input -> tx_out=1, busy_out=0, ready_out=1, fifo_count_out=0 for 200 cycles.
2. cts_n_in=0, push 0xA5 -> tx_out sequence, one bit per 8 cycles, is 0 (start), 1,0,1,0,0,1,0,1 (LSB first), 1 (stop). Frame is 80 cycles; busy_out high for exactly those 80. A reference `uart_rx` instance with BAUD_COUNT=8 outputs 0xA5.
3. cts_n_in=1, push 0x01,0x02,0x03,0x04 back-to-back:
   - ready_out drops after the 4th push and fifo_count_out=4.
   - A 5th valid_in with 0xFF is not accepted.
   - tx_out stays high.
   - Drop cts_n_in -> four frames 0x01..0x04 back-to-back with no idle cycles between stop and start bits (320 cycles total); count goes 3,2,1,0.
4. Raise cts_n_in during bit 3 of frame 0x3C, with 0x7E queued -> 0x3C completes. FSM sits in IDLE with tx_out=1 and fifo_count_out=1. After cts_n_in falls, the 0x7E start bit begins within 3 cycles.
5. Assert rst_n_in low during DATA of 0x55 with 2 bytes queued -> in the same cycle tx_out=1, busy_out=0 and fifo_count_out=0. After release, no frame is emitted.
6. Keep FIFO at count 3 while sending, pushing one byte in the same cycle as each pop -> count stays 3 and no byte is lost or duplicated. A scoreboard over 20 random bytes matches the `uart_rx` output.
